// File: rtl/ibex_pkg.sv
// ibex_pkg: MUL/DIV operator encoding and issue-sequencer types shared by the multdiv slice.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } md_issue_fsm_e;

    localparam int MD_MAX_LATENCY = 38;

    function automatic logic is_mult(md_op_e op);
        return op == MD_OP_MULL || op == MD_OP_MULH;
    endfunction

endpackage

// File: rtl/ibex_multdiv_rsp_buf.sv
// ibex_multdiv_rsp_buf: one-entry result holding register with valid/ready and flush.
module ibex_multdiv_rsp_buf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  logic [31:0] data_in,
    output logic        valid,
    output logic [31:0] data
);

    // Flush wins over everything so a killed result never becomes visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ibex_multdiv_issue.sv
// ibex_multdiv_issue: request sequencer in front of the iterative MUL/DIV unit.
// Optional performance counters are built when IBEX_MULTDIV_PERF_CNT_EN is defined.
module ibex_multdiv_issue
    import ibex_pkg::*;
#(
    parameter logic DataIndTiming = 1'b0,
    parameter int   MaxLatency    = MD_MAX_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic        kill_i,
    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic        md_mult_sel_o,
    output logic        md_div_sel_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    output logic        md_data_ind_timing_o,
    output logic        md_ready_id_o,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        busy_o,
`ifdef IBEX_MULTDIV_PERF_CNT_EN
    output logic [31:0] perf_mul_cnt_o,
    output logic [31:0] perf_div_cnt_o,
    output logic [31:0] perf_busy_cyc_o,
`endif
    output logic        timeout_o
);

    md_issue_fsm_e state, state_next;
    md_op_e        op;
    logic [1:0]    mode;
    logic [31:0]   op_a, op_b;
    logic [5:0]    cnt;
    logic          timeout, accept, unit_busy, mult, load;

    assign accept = req_valid_i & req_ready_o;
    assign mult   = is_mult(op);

    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? ISSUE : IDLE;
            ISSUE:   state_next = md_valid_i ? (kill_i ? IDLE : RESP) : (kill_i ? DRAIN : ISSUE);
            DRAIN:   state_next = md_valid_i ? IDLE : DRAIN;
            RESP:    state_next = kill_i ? IDLE : accept ? ISSUE : rsp_ready_i ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // DRAIN drives the unit exactly like ISSUE so it can walk back to its idle state.
    always_comb begin
        unit_busy     = state == ISSUE || state == DRAIN;
        req_ready_o   = ~kill_i & (state == IDLE || (state == RESP && rsp_ready_i));
        md_mult_en_o  = unit_busy & mult;
        md_mult_sel_o = unit_busy & mult;
        md_div_en_o   = unit_busy & ~mult;
        md_div_sel_o  = unit_busy & ~mult;
        md_ready_id_o = unit_busy & md_valid_i;
        busy_o        = state != IDLE;
        load          = state == ISSUE && md_valid_i && !kill_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op   <= MD_OP_MULL;
            mode <= '0;
            op_a <= '0;
            op_b <= '0;
        end else if (accept) begin
            op   <= md_op_e'(req_operator_i);
            mode <= req_signed_mode_i;
            op_a <= req_op_a_i;
            op_b <= req_op_b_i;
        end
    end

    // Timeout rises on the same edge the saturating counter reaches MaxLatency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            if (accept)
                cnt <= '0;
            else if (unit_busy && cnt != '1)
                cnt <= cnt + 6'd1;
            if (unit_busy && cnt != '1 && int'(cnt) + 1 == MaxLatency)
                timeout <= 1'b1;
        end
    end

    ibex_multdiv_rsp_buf u_rsp_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (load),
        .flush   (kill_i),
        .ready   (rsp_ready_i),
        .data_in (md_result_i),
        .valid   (rsp_valid_o),
        .data    (rsp_result_o)
    );

    assign md_operator_o        = op;
    assign md_signed_mode_o     = mode;
    assign md_op_a_o            = op_a;
    assign md_op_b_o            = op_b;
    assign md_data_ind_timing_o = DataIndTiming;
    assign timeout_o            = timeout;

`ifdef IBEX_MULTDIV_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_mul_cnt_o  <= '0;
            perf_div_cnt_o  <= '0;
            perf_busy_cyc_o <= '0;
        end else begin
            if (rsp_valid_o && rsp_ready_i && !kill_i) begin
                if (mult)
                    perf_mul_cnt_o <= perf_mul_cnt_o + 32'd1;
                else
                    perf_div_cnt_o <= perf_div_cnt_o + 32'd1;
            end
            if (unit_busy)
                perf_busy_cyc_o <= perf_busy_cyc_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// tb_ibex_multdiv_issue: directed plus randomized transactions against a behavioural MUL/DIV reference.
module tb_ibex_multdiv_issue;

    logic        clk = 1'b0;
    logic        rst, req_valid, kill, md_valid, rsp_ready;
    logic [1:0]  req_operator, req_signed_mode;
    logic [31:0] req_op_a, req_op_b, md_result;
    logic        req_ready, mult_en, div_en, mult_sel, div_sel, ind_timing, ready_id;
    logic        rsp_valid, busy, timeout;
    logic [1:0]  md_operator, md_signed_mode;
    logic [31:0] md_op_a, md_op_b, rsp_result;
`ifdef IBEX_MULTDIV_PERF_CNT_EN
    logic [31:0] perf_mul, perf_div, perf_busy;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned exp_mul = 0, exp_div = 0, exp_busy = 0;

    always #5 clk = ~clk;

    ibex_multdiv_issue dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_operator_i       (req_operator),
        .req_signed_mode_i    (req_signed_mode),
        .req_op_a_i           (req_op_a),
        .req_op_b_i           (req_op_b),
        .kill_i               (kill),
        .md_mult_en_o         (mult_en),
        .md_div_en_o          (div_en),
        .md_mult_sel_o        (mult_sel),
        .md_div_sel_o         (div_sel),
        .md_operator_o        (md_operator),
        .md_signed_mode_o     (md_signed_mode),
        .md_op_a_o            (md_op_a),
        .md_op_b_o            (md_op_b),
        .md_data_ind_timing_o (ind_timing),
        .md_ready_id_o        (ready_id),
        .md_valid_i           (md_valid),
        .md_result_i          (md_result),
        .rsp_valid_o          (rsp_valid),
        .rsp_ready_i          (rsp_ready),
        .rsp_result_o         (rsp_result),
        .busy_o               (busy),
`ifdef IBEX_MULTDIV_PERF_CNT_EN
        .perf_mul_cnt_o       (perf_mul),
        .perf_div_cnt_o       (perf_div),
        .perf_busy_cyc_o      (perf_busy),
`endif
        .timeout_o            (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RISC-V M-extension semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] mode,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = mode[0] ? longint'($signed(a)) : longint'({32'd0, a});
        sb = mode[1] ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        if (op == 2'd0) return p[31:0];
        if (op == 2'd1) return p[63:32];
        if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
        return (op == 2'd2) ? 32'(sa / sb) : 32'(sa % sb);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_en"}, {mult_en, div_en, mult_sel, div_sel, ready_id}, 0);
    endtask

    // Called at a drive point with the DUT in IDLE, or in RESP with rsp_ready held high.
    task automatic run_op(input logic [1:0] op, input logic [1:0] mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int kill_at, input int rsp_wait, input bit kill_resp, input bit keep);
        bit mul;
        bit killed;
        mul = op < 2'd2;
        killed = 1'b0;
        req_valid = 1'b1;
        req_operator = op;
        req_signed_mode = mode;
        req_op_a = a;
        req_op_b = b;
        #1;
        check("req_ready_accept", req_ready, 1);
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op_a = $urandom;
        req_op_b = $urandom;
        req_operator = 2'($urandom);
        req_signed_mode = 2'($urandom);
        for (int i = 1; i <= lat; i++) begin
            md_valid = (i == lat);
            md_result = ref_md(op, mode, a, b);
            kill = killed ? 1'($urandom_range(0, 1)) : (i == kill_at);
            #1;
            check("issue_busy", busy, 1);
            check("mult_en", mult_en, mul);
            check("mult_sel", mult_sel, mul);
            check("div_en", div_en, !mul);
            check("div_sel", div_sel, !mul);
            check("op_a_stable", md_op_a, a);
            check("op_b_stable", md_op_b, b);
            check("operator", md_operator, op);
            check("signed_mode", md_signed_mode, mode);
            check("ready_id", ready_id, i == lat);
            check("issue_req_ready", req_ready, 0);
            check("issue_rsp_valid", rsp_valid, 0);
            if (i == kill_at) killed = 1'b1;
            exp_busy++;
            step();
        end
        md_valid = 1'b0;
        kill = 1'b0;
        if (killed) begin
            #1;
            check_idle_outputs("after_kill");
            check("after_kill_req_ready", req_ready, 1);
            return;
        end
        for (int w = 0; w <= rsp_wait; w++) begin
            rsp_ready = (w == rsp_wait);
            kill = kill_resp && w == rsp_wait;
            #1;
            check("rsp_valid", rsp_valid, 1);
            check("rsp_result", rsp_result, exp);
            check("resp_en", {mult_en, div_en, mult_sel, div_sel, ready_id}, 0);
            check("resp_busy", busy, 1);
            check("resp_req_ready", req_ready, w == rsp_wait && !kill_resp);
            if (w < rsp_wait) step();
        end
        if (!kill_resp) begin
            if (mul) exp_mul++;
            else exp_div++;
        end
        check("timeout_quiet", timeout, 0);
        if (keep && !kill_resp) return;
        step();
        rsp_ready = 1'b0;
        kill = 1'b0;
        #1;
        check_idle_outputs("after_rsp");
    endtask

    initial begin
        bit pending;
        rst = 1'b1;
        req_valid = 1'b0;
        kill = 1'b0;
        md_valid = 1'b0;
        rsp_ready = 1'b0;
        req_operator = '0;
        req_signed_mode = '0;
        req_op_a = '0;
        req_op_b = '0;
        md_result = '0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset_timeout", timeout, 0);
        check("reset_operands", md_op_a | md_op_b, 0);
        check("reset_result", rsp_result, 0);
        check("ind_timing", ind_timing, 0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1);

        run_op(2'd0, 2'b00, 32'd7, 32'd6, 32'd42, 3, 0, 0, 0, 0);
        run_op(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 37, 0, 1, 0, 0);
        run_op(2'd3, 2'b00, 32'd10, 32'd3, 32'd1, 4, 0, 0, 0, 1);
        run_op(2'd1, 2'b11, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 2, 0, 0, 0, 0);
        run_op(2'd2, 2'b11, 32'd100, 32'd7, 32'd14, 20, 5, 0, 0, 0);
        run_op(2'd0, 2'b00, 32'd3, 32'd5, 32'd15, 2, 0, 1, 1, 0);
        run_op(2'd2, 2'b00, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        run_op(2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5, 0, 0, 0, 0);

        pending = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op, mode;
            logic [31:0] a, b;
            int          lat, kill_at;
            bit          kill_resp, keep;
            op = 2'($urandom);
            mode = (op < 2'd2) ? 2'($urandom) : ($urandom_range(0, 1) ? 2'b11 : 2'b00);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            lat = $urandom_range(1, 37);
            kill_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
            kill_resp = kill_at == 0 && $urandom_range(0, 5) == 0;
            keep = kill_at == 0 && !kill_resp && $urandom_range(0, 1);
            run_op(op, mode, a, b, ref_md(op, mode, a, b), lat, kill_at,
                   $urandom_range(0, 3), kill_resp, keep);
            pending = keep;
        end
        if (pending) begin
            step();
            rsp_ready = 1'b0;
            #1;
            check_idle_outputs("drain_pending");
        end

`ifdef IBEX_MULTDIV_PERF_CNT_EN
        check("perf_mul", perf_mul, exp_mul);
        check("perf_div", perf_div, exp_div);
        check("perf_busy", perf_busy, exp_busy);
`endif

        // Unit never answers: watchdog must fire after 38 ISSUE cycles and stick.
        req_valid = 1'b1;
        req_operator = 2'd2;
        req_signed_mode = 2'b11;
        req_op_a = 32'd1;
        req_op_b = 32'd1;
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            #1;
            check("watchdog", timeout, i > 38);
            check("watchdog_busy", busy, 1);
            step();
        end
        kill = 1'b1;
        step();
        kill = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_div_en", div_en, 1);
            check("timeout_sticky", timeout, 1);
            step();
        end
        rst = 1'b1;
        step();
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_timeout", timeout, 0);
        check("mid_reset_operands", md_op_a | md_op_b | 32'(md_operator) | 32'(md_signed_mode), 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
